wvb_readout_ctrl: RTL

Readout controller for the mDOM waveform buffer storage. It pops one header per stored waveform from the header FIFO, extracts the waveform's start and stop addresses, and walks the waveform BRAM read port from start to stop with address wrap-around. Samples go to a downstream valid/ready stream. When a waveform is fully read, it reports the freed buffer pointer back to the writer side.

---
 rtl/wvb_pkg.sv | 15 +
 rtl/wvb_rd_skid.sv | 69 ++++++
 rtl/wvb_readout_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wvb_pkg.sv
// Shared definitions for the waveform buffer readout path.
// The header field offsets are also used by the header writer.
package wvb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    STREAM,
    DONE
  } rd_state_e;

  localparam int HDR_START_LSB = 0;
  localparam int HDR_STOP_LSB  = 12;

endpackage

// File: rtl/wvb_rd_skid.sv
// Two-entry {data, last} FIFO between the BRAM return path and the sample stream.
// When it is empty, a returning word is presented on the output in the same cycle.
module wvb_rd_skid #(
  parameter int P_DATA_WIDTH = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [P_DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [P_DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic [1:0]              count
);

  logic [P_DATA_WIDTH-1:0] data_q [2];
  logic                    last_q [2];
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic [1:0]              count_q;
  logic                    head_valid;
  logic                    pop;
  logic                    pop_stored;
  logic                    store;

  assign head_valid = (count_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign pop_stored = pop && head_valid;
  // A word that arrives into an empty FIFO and is taken at once is never stored.
  assign store      = in_valid && !(pop && !head_valid);
  assign wr_ptr     = rd_ptr ^ count_q[0];
  assign count      = count_q;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    out_valid = head_valid || in_valid;
    out_data  = '0;
    out_last  = 1'b0;
    if (head_valid) begin
      out_data = data_q[rd_ptr];
      out_last = last_q[rd_ptr];
    end else if (in_valid) begin
      out_data = in_data;
      out_last = in_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      rd_ptr  <= 1'b0;
    end else begin
      count_q <= count_q + 2'(store) - 2'(pop_stored);
      if (pop_stored) rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: storage needs no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (store) begin
      data_q[wr_ptr] <= in_data;
      last_q[wr_ptr] <= in_last;
    end
  end

endmodule

// File: rtl/wvb_readout_ctrl.sv
// Pops one header per stored waveform, walks the BRAM from start to stop with
// wrap-around, streams the samples out and reports the freed buffer pointer.
module wvb_readout_ctrl
  import wvb_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_START_LSB  = HDR_START_LSB,
  parameter int P_STOP_LSB   = HDR_STOP_LSB
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_HDR_WIDTH-1:0]  hdr_out,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    evt_done,
  output logic [P_ADR_WIDTH-1:0]  rd_ptr_free,
  output logic                    eoe_err
);

  localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = P_ADR_WIDTH'(1);

  rd_state_e              state;
  rd_state_e              state_n;
  logic [P_ADR_WIDTH-1:0] hdr_start;
  logic [P_ADR_WIDTH-1:0] hdr_stop;
  logic [P_ADR_WIDTH-1:0] stop_q;
  logic                   last_issued;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic                   issue;
  logic [1:0]             skid_count;
  logic                   beat_accept;

  assign hdr_start   = hdr_data[P_START_LSB +: P_ADR_WIDTH];
  assign hdr_stop    = hdr_data[P_STOP_LSB +: P_ADR_WIDTH];
  assign beat_accept = dout_valid && dout_ready;
  // The stored eoe bit travels with the beat as dout[0].
  assign eoe_err     = beat_accept && (dout[0] != dout_last);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    hdr_rdreq = 1'b0;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by rst_n so nothing is popped while the block is held in reset.
        if (rst_n && en && !hdr_empty) begin
          hdr_rdreq = 1'b1;
          state_n   = LATCH;
        end
      end
      LATCH: state_n = STREAM;
      STREAM: begin
        // At most two words may be stored or returning, so the skid never overflows.
        issue = !last_issued && ((skid_count + {1'b0, inflight_q}) < 2'd2);
        if (beat_accept && dout_last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wvb_rd_addr     <= '0;
      hdr_out         <= '0;
      stop_q          <= '0;
      last_issued     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      evt_done        <= 1'b0;
      rd_ptr_free     <= '0;
    end else begin
      evt_done        <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (wvb_rd_addr == stop_q);
      if (state == LATCH) begin
        hdr_out     <= hdr_data;
        stop_q      <= hdr_stop;
        wvb_rd_addr <= hdr_start;
        last_issued <= 1'b0;
      end
      if (issue) begin
        wvb_rd_addr <= wvb_rd_addr + ADR_ONE;
        if (wvb_rd_addr == stop_q) last_issued <= 1'b1;
      end
      if (state == STREAM && beat_accept && dout_last) begin
        evt_done    <= 1'b1;
        rd_ptr_free <= stop_q + ADR_ONE;
      end
    end
  end

  wvb_rd_skid #(
    .P_DATA_WIDTH(P_DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_data  (wvb_data),
    .in_last  (inflight_last_q),
    .out_ready(dout_ready),
    .out_valid(dout_valid),
    .out_data (dout),
    .out_last (dout_last),
    .count    (skid_count)
  );

endmodule
